// File: rtl/imm_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pkg
//  Description : Shared types and opcode constants for the immediate
//                generation stage (format codes, RV base opcodes).
//  Revision    : 1.0 - initial release
// ============================================================================
package imm_gen_pkg;

  // Format tag attached to every generated immediate
  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_CSR   = 3'd7
  } imm_fmt_e;

  // Base-ISA major opcodes, inst[6:0]
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
//  Module      : imm_decode
//  Description : Combinational instruction -> {immediate, format, illegal}
//                decoder for all RV base-ISA immediate formats.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  // Every format fits in 32 bits; zero-extended formats keep bit 31 clear,
  // so a single sign-fill to XLEN covers all of them.
  logic [31:0] val32;
  logic [31:0] shamt_ext;
  logic        sgn;

  assign sgn = inst_i[31];

  // RV64 shifts use a 6-bit amount, RV32 a 5-bit one
  if (XLEN == 64) begin : g_shamt64
    assign shamt_ext = {26'b0, inst_i[25:20]};
  end else begin : g_shamt32
    assign shamt_ext = {27'b0, inst_i[24:20]};
  end

  // Opcode decode: pick the format and assemble its 32-bit immediate
  always_comb begin
    val32     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    case (inst_i[6:0])
      OP_LOAD, OP_JALR: begin
        fmt_o = FMT_I;
        val32 = {{20{sgn}}, inst_i[31:20]};
      end
      OP_IMM: begin
        if (inst_i[14:12] == 3'b001 || inst_i[14:12] == 3'b101) begin
          fmt_o = FMT_SHAMT;
          val32 = shamt_ext;
        end else begin
          fmt_o = FMT_I;
          val32 = {{20{sgn}}, inst_i[31:20]};
        end
      end
      OP_STORE: begin
        fmt_o = FMT_S;
        val32 = {{20{sgn}}, inst_i[31:25], inst_i[11:7]};
      end
      OP_BRANCH: begin
        fmt_o = FMT_B;
        val32 = {{19{sgn}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt_o = FMT_U;
        val32 = {inst_i[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt_o = FMT_J;
        val32 = {{11{sgn}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      OP_SYSTEM: begin
        if (inst_i[14]) begin
          fmt_o = FMT_CSR;
          val32 = {27'b0, inst_i[19:15]};
        end
      end
      OP_REG, OP_FENCE: begin
        fmt_o = FMT_NONE;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

  // Sign-fill the upper bits from bit 31 of the 32-bit value
  always_comb begin
    imm_o       = {XLEN{val32[31]}};
    imm_o[31:0] = val32;
  end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Registered, valid/ready immediate-generation stage with a
//                2-entry skid buffer, flush and saturating illegal counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic [XLEN-1:0] pc;
    logic            ill;
  } entry_t;

  entry_t           dec_w;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             drain;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst_i    (in_inst),
    .imm_o     (dec_w.imm),
    .fmt_o     (dec_w.fmt),
    .illegal_o (dec_w.ill)
  );
  assign dec_w.pc = in_pc;

  // Ready depends only on skid occupancy, so there is no in->out comb path
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~flush;
  assign drain    = main_valid_q & out_ready;

  // Buffer control: skid word refills main first so order is preserved
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no new word can arrive this cycle
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec_w;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec_w;
      skid_valid_d = 1'b1;
    end
  end

  // Saturating count of accepted illegal words; flush does not touch it
  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec_w.ill && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_pc      = main_q.pc;
  assign out_illegal = main_q.ill;
  assign illegal_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Self-checking bench for imm_gen_pipe; drives an XLEN=32
//                (CNT_W=2) and an XLEN=64 (CNT_W=8) instance in lockstep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        r32_in_ready, r32_out_valid, r32_out_illegal;
  logic [31:0] r32_out_imm, r32_out_pc;
  logic [2:0]  r32_out_fmt;
  logic [1:0]  r32_cnt;

  logic        r64_in_ready, r64_out_valid, r64_out_illegal;
  logic [63:0] r64_out_imm, r64_out_pc;
  logic [2:0]  r64_out_fmt;
  logic [7:0]  r64_cnt;

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r32_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .out_valid(r32_out_valid), .out_ready(out_ready),
    .out_imm(r32_out_imm), .out_fmt(r32_out_fmt), .out_pc(r32_out_pc),
    .out_illegal(r32_out_illegal), .illegal_cnt(r32_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(8)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r64_in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(r64_out_valid), .out_ready(out_ready),
    .out_imm(r64_out_imm), .out_fmt(r64_out_fmt), .out_pc(r64_out_pc),
    .out_illegal(r64_out_illegal), .illegal_cnt(r64_cnt)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] pc;
    logic        ill;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   cnt32 = 0;
  int   cnt64 = 0;
  int   total = 0;
  int   bad   = 0;

  // Reference: field extraction and sign handling done with integer arithmetic
  function automatic exp_t ref_model(input logic [31:0] w, input logic [63:0] pc, input bit x64);
    exp_t   r;
    longint v;
    int     f, op, f3;
    bit     ill;
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    v = 0; f = 0; ill = 1'b0;
    case (op)
      'h03, 'h67: begin
        f = 1; v = longint'(w[31:20]); if (v >= 2048) v -= 4096;
      end
      'h13: begin
        if (f3 == 1 || f3 == 5) begin
          f = 6; v = x64 ? longint'(w[25:20]) : longint'(w[24:20]);
        end else begin
          f = 1; v = longint'(w[31:20]); if (v >= 2048) v -= 4096;
        end
      end
      'h23: begin
        f = 2; v = longint'(w[31:25]) * 32 + longint'(w[11:7]); if (v >= 2048) v -= 4096;
      end
      'h63: begin
        f = 3;
        v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      'h37, 'h17: begin
        f = 4; v = longint'(w[31:12]) * 4096; if (w[31]) v -= (longint'(1) << 32);
      end
      'h6f: begin
        f = 5;
        v = longint'(w[31]) * (1 << 20) + longint'(w[19:12]) * (1 << 12) + longint'(w[20]) * (1 << 11) + longint'(w[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      'h73: begin
        if (w[14]) begin f = 7; v = longint'(w[19:15]); end
      end
      'h33, 'h0f: begin f = 0; end
      default: ill = 1'b1;
    endcase
    r.imm = x64 ? v : (v & 64'hFFFF_FFFF);
    r.fmt = 3'(f);
    r.pc  = x64 ? pc : (pc & 64'hFFFF_FFFF);
    r.ill = ill;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare both instances against the model's current contents
  task automatic check_state();
    int n;
    n = q32.size();
    chk("in_ready32", 64'(r32_in_ready), 64'(n < 2));
    chk("in_ready64", 64'(r64_in_ready), 64'(n < 2));
    chk("out_valid32", 64'(r32_out_valid), 64'(n > 0));
    chk("out_valid64", 64'(r64_out_valid), 64'(n > 0));
    if (n > 0) begin
      chk("imm32", 64'(r32_out_imm), q32[0].imm);
      chk("fmt32", 64'(r32_out_fmt), 64'(q32[0].fmt));
      chk("pc32", 64'(r32_out_pc), q32[0].pc);
      chk("ill32", 64'(r32_out_illegal), 64'(q32[0].ill));
      chk("imm64", r64_out_imm, q64[0].imm);
      chk("fmt64", 64'(r64_out_fmt), 64'(q64[0].fmt));
      chk("pc64", r64_out_pc, q64[0].pc);
      chk("ill64", 64'(r64_out_illegal), 64'(q64[0].ill));
    end
    chk("cnt32", 64'(r32_cnt), 64'(cnt32));
    chk("cnt64", 64'(r64_cnt), 64'(cnt64));
  endtask

  // One clock cycle: drive, check, clock, advance the model
  task automatic step(input logic v, input logic [31:0] w, input logic [63:0] pc,
                      input logic rdy, input logic fl, output bit acc);
    int   n;
    bit   drn;
    exp_t e32, e64;
    in_valid = v; in_inst = w; in_pc = pc; out_ready = rdy; flush = fl;
    check_state();
    @(posedge clk);
    n   = q32.size();
    acc = v && (n < 2) && !fl;
    drn = (n > 0) && rdy;
    if (fl) begin
      q32.delete();
      q64.delete();
    end else begin
      if (drn) begin
        void'(q32.pop_front());
        void'(q64.pop_front());
      end
      if (acc) begin
        e32 = ref_model(w, pc, 1'b0);
        e64 = ref_model(w, pc, 1'b1);
        q32.push_back(e32);
        q64.push_back(e64);
        if (e32.ill) begin
          if (cnt32 < 3)   cnt32++;
          if (cnt64 < 255) cnt64++;
        end
      end
    end
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, 64'(r32_out_valid | r64_out_valid), 64'd0);
    chk({tag, "_ready"}, 64'(r32_in_ready & r64_in_ready), 64'd1);
    chk({tag, "_imm"}, r64_out_imm | 64'(r32_out_imm), 64'd0);
    chk({tag, "_pc"}, r64_out_pc | 64'(r32_out_pc), 64'd0);
    chk({tag, "_fmt"}, 64'(r32_out_fmt | r64_out_fmt), 64'd0);
    chk({tag, "_ill"}, 64'(r32_out_illegal | r64_out_illegal), 64'd0);
    chk({tag, "_cnt"}, 64'(r32_cnt) | 64'(r64_cnt), 64'd0);
  endtask

  logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
                           7'h17, 7'h6f, 7'h73, 7'h33, 7'h0f};

  initial begin
    bit          a;
    logic [31:0] w;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    rst_n = 1'b1;

    // Directed immediates, out_ready high
    step(1'b1, 32'h123450B7, 64'h100, 1'b1, 1'b0, a);
    chk("lui_imm32", 64'(r32_out_imm), 64'h12345000);
    chk("lui_fmt32", 64'(r32_out_fmt), 64'd4);
    chk("lui_imm64", r64_out_imm, 64'h12345000);
    step(1'b1, 32'hFFF00093, 64'h104, 1'b1, 1'b0, a);
    chk("addi_imm32", 64'(r32_out_imm), 64'hFFFFFFFF);
    chk("addi_fmt32", 64'(r32_out_fmt), 64'd1);
    chk("addi_imm64", r64_out_imm, 64'hFFFFFFFFFFFFFFFF);
    step(1'b1, 32'hFE000EE3, 64'h108, 1'b1, 1'b0, a);
    chk("beq_imm32", 64'(r32_out_imm), 64'hFFFFFFFC);
    chk("beq_fmt32", 64'(r32_out_fmt), 64'd3);
    chk("beq_imm64", r64_out_imm, 64'hFFFFFFFFFFFFFFFC);
    step(1'b1, 32'h4030D093, 64'h10C, 1'b1, 1'b0, a);
    chk("srai_imm32", 64'(r32_out_imm), 64'h3);
    chk("srai_fmt32", 64'(r32_out_fmt), 64'd6);
    chk("srai_imm64", r64_out_imm, 64'h3);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, a);

    // Back-pressure: A and B held, C refused until space frees
    step(1'b1, 32'h00100093, 64'hA0, 1'b0, 1'b0, a);
    step(1'b1, 32'h00200093, 64'hB0, 1'b0, 1'b0, a);
    chk("bp_ready_low32", 64'(r32_in_ready), 64'd0);
    chk("bp_ready_low64", 64'(r64_in_ready), 64'd0);
    step(1'b1, 32'h00300093, 64'hC0, 1'b0, 1'b0, a);
    chk("bp_hold_pc", 64'(r32_out_pc), 64'hA0);
    a = 1'b0;
    for (int k = 0; k < 8 && !a; k++) step(1'b1, 32'h00300093, 64'hC0, 1'b1, 1'b0, a);
    repeat (3) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, a);

    // Illegal-opcode saturation
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h0000007F, 64'(32'h200 + 4 * i), 1'b1, 1'b0, a);
      chk("sat_ill", 64'(r32_out_illegal), 64'd1);
      chk("sat_imm", 64'(r32_out_imm), 64'd0);
      chk("sat_cnt", 64'(r32_cnt), 64'((i + 1 > 3) ? 3 : i + 1));
    end
    step(1'b1, 32'h00000033, 64'h300, 1'b1, 1'b0, a);
    chk("reg_ill", 64'(r32_out_illegal), 64'd0);
    chk("reg_cnt", 64'(r32_cnt), 64'd3);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, a);

    // Flush with both entries full and a word offered
    step(1'b1, 32'h00500013, 64'h400, 1'b0, 1'b0, a);
    step(1'b1, 32'h00600013, 64'h404, 1'b0, 1'b0, a);
    step(1'b1, 32'h0000007F, 64'h408, 1'b0, 1'b1, a);
    chk("flush_valid", 64'(r32_out_valid | r64_out_valid), 64'd0);
    chk("flush_ready", 64'(r32_in_ready & r64_in_ready), 64'd1);
    chk("flush_cnt64", 64'(r64_cnt), 64'd5);
    repeat (3) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, a);

    // Asynchronous reset in the middle of a stream
    step(1'b1, 32'h00700013, 64'h500, 1'b0, 1'b0, a);
    step(1'b1, 32'h0000007F, 64'h504, 1'b0, 1'b0, a);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("async");
    q32.delete(); q64.delete(); cnt32 = 0; cnt64 = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 32'h123450B7, 64'h600, 1'b1, 1'b0, a);
    chk("post_rst_valid", 64'(r32_out_valid), 64'd1);
    chk("post_rst_imm", 64'(r32_out_imm), 64'h12345000);

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 15) < 11) w[6:0] = ops[$urandom_range(0, 10)];
      step($urandom_range(0, 3) != 0, w, {$urandom, $urandom},
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, a);
    end
    check_state();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate-generation stage for the RV decode path, parametrised in XLEN (32/64).
- Covers every base-ISA immediate format: I, S, B, U (LUI/AUIPC), J, JALR, shift-amount and CSR zimm.
- Tags each result with a format code and an illegal-opcode flag; keeps a saturating illegal-opcode counter.
- Sits between fetch and register read; a 2-entry skid buffer keeps full throughput under back-pressure.

Parameters:
- XLEN, 32, datapath width of out_imm/in_pc/out_pc; legal values 32 or 64.
- CNT_W, 8, width of the illegal-opcode counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush
- in_valid  input  1  upstream word valid
- in_ready  output  1  stage can accept
- in_inst  input  32  instruction word
- in_pc  input  XLEN  PC tag, passed through unchanged
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_imm  output  XLEN  generated immediate
- out_fmt  output  3  imm_fmt_e code
- out_pc  output  XLEN  PC of the result
- out_illegal  output  1  opcode not recognised
- illegal_cnt  output  CNT_W  saturating count of accepted illegal words

Behaviour:
- Reset (async, rst_n low): out_valid=0, skid empty, in_ready=1, out_imm/out_pc=0, out_fmt=FMT_NONE, out_illegal=0, illegal_cnt=0. Reset mid-transfer drops all held words.
- Decode by opcode inst[6:0]; sx() = sign-extend from inst[31] to XLEN:
  - 0000011, 1100111: I, sx(inst[31:20]).
  - 0010011 with funct3 001/101: SHAMT, zero-extended inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64).
  - 0010011 otherwise: I.
  - 0100011: S, sx({inst[31:25],inst[11:7]}).
  - 1100011: B, sx({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 0110111, 0010111: U, sx({inst[31:12],12'b0}); on XLEN=64 bits 63:32 copy inst[31].
  - 1101111: J, sx({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - 1110011 with funct3[2]=1: CSR, zero-extended inst[19:15].
  - 0110011, 0001111, 1110011 with funct3[2]=0: NONE, imm=0, illegal=0.
  - Anything else: NONE, imm=0, illegal=1.
- Handshake: a transfer occurs when valid&ready on a cycle edge. Latency 1 cycle, throughput 1 word/cycle.
- Storage: main output register plus one skid register.
  - If out_ready is low while the main register is full and a word is accepted, that word goes to the skid register.
  - in_ready = !skid_valid (registered, no combinational in→out path).
  - When the main register drains, the skid word moves into it first. Order is always preserved.
- flush: clears main_valid and skid_valid at the next edge; in_ready=1 the cycle after. A word offered in the flush cycle is discarded, not counted. Flush has priority over accept and does not clear illegal_cnt.
- illegal_cnt: +1 per accepted illegal word; saturates at 2^CNT_W−1, no wrap.
- Output fields are stable while out_valid&!out_ready.

Decomposition:
- Package imm_gen_pkg holds:
  - imm_fmt_e: NONE=0, I, S, B, U, J, SHAMT, CSR.
  - Opcode localparams OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM, OP_REG, OP_FENCE.
- Sub-module imm_decode: combinational inst→{imm, fmt, illegal}, parametrised by XLEN. Top level holds the skid buffer, flush logic and counter.

Test Plan:
- Immediate values, XLEN=32, out_ready=1:
  - LUI 0x123450B7 → next cycle imm 0x12345000, fmt U.
  - addi 0xFFF00093 → imm 0xFFFFFFFF, fmt I.
  - beq 0xFE000EE3 → imm 0xFFFFFFFC, fmt B.
  - srai 0x4030D093 → imm 0x00000003, fmt SHAMT.
  - Repeat with XLEN=64: addi → 0xFFFFFFFFFFFFFFFF, srai → 0x3.
- Back-pressure: out_ready=0, stream A,B,C → A and B accepted, in_ready=0 on the C cycle. Raise out_ready → A,B,C delivered in order, no loss or duplicate.
- Illegal saturation: CNT_W=2, five words 0x0000007F → each out_illegal=1, imm=0; illegal_cnt 1,2,3,3,3. 0x00000033 → illegal=0, count unchanged.
- Flush: main and skid full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, counter unchanged, flushed-cycle word never appears.
- Async reset: drop rst_n mid-stream between edges → outputs reset immediately. After release the first accepted word appears 1 cycle later.
